present_core_param: RTL

Iterative PRESENT block-cipher core, one round per clock, with a valid/ready handshake on both input and output. It generalises the fixed PRESENT-80 encrypt-only datapath in three ways: key width is set by parameter (80 or 128), encrypt or decrypt is chosen per block, and a decrypt-key pre-expansion phase is added. It sits between a host-side input FIFO/bus adapter and the ciphertext consumer.

---
 rtl/present_core_param.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/present_core_param.sv
// present_core_param: iterative PRESENT block cipher, one round per clock, encrypt or decrypt per block
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   input handshake; in_ready is high only while idle
//   in_decrypt          0 = encrypt, 1 = decrypt, sampled at the handshake
//   in_data, in_key     64-bit block and KEY_WIDTH-bit user key
//   out_valid/out_ready output handshake; out_data held until accepted
//   busy                high while expanding the decrypt key or running rounds
// Optional: define PRESENT_DEC_KEY_CACHE_EN to remember the last K32 so a decrypt
// under the same key skips key expansion.
module present_core_param #(
  parameter int KEY_WIDTH = 80,
  parameter int ROUNDS    = 31
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_decrypt,
  input  logic [63:0]          in_data,
  input  logic [KEY_WIDTH-1:0] in_key,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [63:0]          out_data,
  output logic                 busy
);
  typedef enum logic [1:0] {IDLE, KEYEXP, RUN, DONE} fsm_t;
  localparam logic [63:0] SBOX = 64'hC56B90AD3EF84712;
  localparam logic [63:0] SINV = 64'h5EF8C12DB463079A;
  localparam int CPOS = (KEY_WIDTH == 128) ? 62 : 15;
  localparam logic [4:0] RMAX = 5'(ROUNDS);
  if (KEY_WIDTH != 80 && KEY_WIDTH != 128) begin : g_bad_key_width
    $error("present_core_param: KEY_WIDTH must be 80 or 128");
  end
  // Nibble x sits at the top of the table when x == 0.
  function automatic logic [3:0] sb(input logic [3:0] x, input logic inv);
    return 4'((inv ? SINV : SBOX) >> {~x, 2'b00});
  endfunction
  function automatic logic [63:0] slayer(input logic [63:0] x, input logic inv);
    logic [63:0] y;
    y = '0;
    for (int n = 0; n < 16; n++) y[4*n +: 4] = sb(x[4*n +: 4], inv);
    return y;
  endfunction
  // Bit i moves to 16*i mod 63; bit 63 stays put.
  function automatic logic [63:0] player(input logic [63:0] x, input logic inv);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++)
      if (inv) y[i] = x[i == 63 ? 63 : (i * 16) % 63];
      else y[i == 63 ? 63 : (i * 16) % 63] = x[i];
    return y;
  endfunction
  function automatic logic [KEY_WIDTH-1:0] kfwd(input logic [KEY_WIDTH-1:0] k, input logic [4:0] i);
    logic [KEY_WIDTH-1:0] r;
    r = {k[KEY_WIDTH-62:0], k[KEY_WIDTH-1:KEY_WIDTH-61]};
    r[KEY_WIDTH-1 -: 4] = sb(r[KEY_WIDTH-1 -: 4], 1'b0);
    if (KEY_WIDTH == 128) r[KEY_WIDTH-5 -: 4] = sb(r[KEY_WIDTH-5 -: 4], 1'b0);
    r[CPOS +: 5] = r[CPOS +: 5] ^ i;
    return r;
  endfunction
  function automatic logic [KEY_WIDTH-1:0] kinv(input logic [KEY_WIDTH-1:0] k, input logic [4:0] i);
    logic [KEY_WIDTH-1:0] r;
    r = k;
    r[CPOS +: 5] = r[CPOS +: 5] ^ i;
    r[KEY_WIDTH-1 -: 4] = sb(r[KEY_WIDTH-1 -: 4], 1'b1);
    if (KEY_WIDTH == 128) r[KEY_WIDTH-5 -: 4] = sb(r[KEY_WIDTH-5 -: 4], 1'b1);
    return {r[60:0], r[KEY_WIDTH-1:61]};
  endfunction
  fsm_t fsm, nxt;
  logic [63:0] state_reg, rk;
  logic [KEY_WIDTH-1:0] key_reg, kf, load_key;
  logic [4:0] rnd;
  logic dec_reg, hit, last;
  assign rk = key_reg[KEY_WIDTH-1 -: 64];
  assign kf = kfwd(key_reg, rnd);
  assign last = dec_reg ? rnd == 5'd1 : rnd == RMAX;
  assign in_ready = fsm == IDLE;
  assign busy = fsm == KEYEXP || fsm == RUN;
`ifdef PRESENT_DEC_KEY_CACHE_EN
  logic [KEY_WIDTH-1:0] cache_key, cache_k32;
  logic cache_vld;
  assign hit = cache_vld && in_key == cache_key;
  assign load_key = (in_decrypt && hit) ? cache_k32 : in_key;
  // The user key is captured at the handshake, so completion only has to record K32;
  // only a reset can abort in between, and that clears the cache anyway.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cache_key <= '0;
      cache_k32 <= '0;
      cache_vld <= 1'b0;
    end else if (fsm == IDLE && in_valid && !(in_decrypt && hit)) begin
      cache_key <= in_key;
      cache_vld <= 1'b0;
    end else if ((fsm == KEYEXP || (fsm == RUN && !dec_reg)) && rnd == RMAX) begin
      cache_k32 <= kf;
      cache_vld <= 1'b1;
    end
`else
  assign hit = 1'b0;
  assign load_key = in_key;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) fsm <= IDLE;
    else fsm <= nxt;
  always_comb begin
    nxt = fsm;
    case (fsm)
      IDLE:    if (in_valid) nxt = (in_decrypt && !hit) ? KEYEXP : RUN;
      KEYEXP:  if (rnd == RMAX) nxt = RUN;
      RUN:     if (last) nxt = DONE;
      DONE:    if (out_valid && out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  // During decrypt key_reg always holds K(rnd+1), so the top slice is the right round key.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_reg <= '0;
      key_reg   <= '0;
      rnd       <= '0;
      dec_reg   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (fsm)
        IDLE: if (in_valid) begin
          state_reg <= in_data;
          key_reg   <= load_key;
          rnd       <= (in_decrypt && hit) ? RMAX : 5'd1;
          dec_reg   <= in_decrypt;
        end
        KEYEXP: begin
          key_reg <= kf;
          rnd     <= (rnd == RMAX) ? rnd : rnd + 5'd1;
        end
        RUN: begin
          state_reg <= dec_reg ? slayer(player(state_reg ^ rk, 1'b1), 1'b1)
                               : player(slayer(state_reg ^ rk, 1'b0), 1'b0);
          key_reg   <= dec_reg ? kinv(key_reg, rnd) : kf;
          rnd       <= last ? rnd : dec_reg ? rnd - 5'd1 : rnd + 5'd1;
        end
        DONE: if (!out_valid) begin
          out_valid <= 1'b1;
          out_data  <= state_reg ^ rk;
        end else if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
endmodule
